// File: rtl/multicycle_main_control.sv
// Multicycle main control FSM for the RISCY datapath: sequences fetch/decode/
// execute/memory/writeback and drives the datapath selects and enables.
module multicycle_main_control #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zero_ext,
  output logic [2:0] alu_op,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       tmo_q, tmo_d;
  logic       in_mem;
  logic       timed_out;

  assign in_mem    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // Ready on the cycle the count hits the limit still wins over the trap.
  assign timed_out = in_mem && !mem_ready && (wait_q == TMO);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_R:                              state_d = S_EXEC_R;
          OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
          default: begin
            state_d   = S_TRAP;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R:   state_d = S_FETCH;
      S_EXEC_I: state_d = S_WB_I;
      S_WB_I:   state_d = S_FETCH;
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_WB_MEM: state_d = S_FETCH;
      S_MEM_WR: if (mem_ready) state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
    if (timed_out) begin
      state_d = S_TRAP;
      tmo_d   = 1'b1;
    end
  end

  // A memory state only self-loops while waiting, so any state change clears the count.
  assign wait_d = (in_mem && (state_d == state_q)) ? wait_q + 8'd1 : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    zero_ext      = 1'b0;
    alu_op        = 3'b000;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        unique case (opcode)
          OP_ANDI: begin alu_op = 3'b100; zero_ext = 1'b1; end
          OP_ORI:  begin alu_op = 3'b101; zero_ext = 1'b1; end
          OP_SLTI: alu_op = 3'b110;
          default: alu_op = 3'b011;
        endcase
      end
      S_WB_I: reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        branch_ne     = (opcode == OP_BNE);
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: ;
    endcase
  end

  assign illegal_op  = illegal_q;
  assign mem_timeout = tmo_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: expected output vectors are queued
// as each cycle's inputs are driven and compared once the outputs settle.
module tb_multicycle_main_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, zero_ext;
  logic       illegal_op, mem_timeout;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  multicycle_main_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_src(pc_src), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .zero_ext(zero_ext), .alu_op(alu_op), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3,
                         WB_R = 4'd4, EXEC_I = 4'd5, WB_I = 4'd6, MEM_ADDR = 4'd7,
                         MEM_RD = 4'd8, WB_MEM = 4'd9, MEM_WR = 4'd10, BRANCH = 4'd11,
                         JUMP = 4'd12, TRAP = 4'd13;
  localparam logic [5:0] JUNK = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_cond, branch_ne;
    logic [1:0] pc_src;
    logic       iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [2:0] alu_op;
    logic       illegal_op, mem_timeout;
  } outs_t;

  outs_t exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  function automatic outs_t observed();
    outs_t o;
    o = '{st: state, pc_write: pc_write, pc_write_cond: pc_write_cond, branch_ne: branch_ne,
          pc_src: pc_src, iord: iord, mem_read: mem_read, mem_write: mem_write,
          ir_write: ir_write, reg_write: reg_write, reg_dst: reg_dst, mem_to_reg: mem_to_reg,
          alu_src_a: alu_src_a, alu_src_b: alu_src_b, zero_ext: zero_ext, alu_op: alu_op,
          illegal_op: illegal_op, mem_timeout: mem_timeout};
    return o;
  endfunction

  function automatic outs_t e_idle();
    outs_t e = '0;
    return e;
  endfunction
  function automatic outs_t e_fetch(input logic rdy);
    outs_t e = '0;
    e.st = FETCH; e.mem_read = 1'b1; e.alu_src_b = 2'b01;
    e.ir_write = rdy; e.pc_write = rdy;
    return e;
  endfunction
  function automatic outs_t e_decode();
    outs_t e = '0;
    e.st = DECODE; e.alu_src_b = 2'b11;
    return e;
  endfunction
  function automatic outs_t e_exec_r();
    outs_t e = '0;
    e.st = EXEC_R; e.alu_src_a = 1'b1; e.alu_op = 3'b010;
    return e;
  endfunction
  function automatic outs_t e_wb_r();
    outs_t e = '0;
    e.st = WB_R; e.reg_write = 1'b1; e.reg_dst = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_exec_i(input logic [2:0] op, input logic z);
    outs_t e = '0;
    e.st = EXEC_I; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = op; e.zero_ext = z;
    return e;
  endfunction
  function automatic outs_t e_wb_i();
    outs_t e = '0;
    e.st = WB_I; e.reg_write = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_maddr();
    outs_t e = '0;
    e.st = MEM_ADDR; e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
    return e;
  endfunction
  function automatic outs_t e_mrd();
    outs_t e = '0;
    e.st = MEM_RD; e.mem_read = 1'b1; e.iord = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_wbm();
    outs_t e = '0;
    e.st = WB_MEM; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_mwr();
    outs_t e = '0;
    e.st = MEM_WR; e.mem_write = 1'b1; e.iord = 1'b1;
    return e;
  endfunction
  function automatic outs_t e_branch(input logic ne);
    outs_t e = '0;
    e.st = BRANCH; e.alu_src_a = 1'b1; e.alu_op = 3'b001; e.pc_write_cond = 1'b1;
    e.pc_src = 2'b01; e.branch_ne = ne;
    return e;
  endfunction
  function automatic outs_t e_jump();
    outs_t e = '0;
    e.st = JUMP; e.pc_write = 1'b1; e.pc_src = 2'b10;
    return e;
  endfunction
  function automatic outs_t e_trap(input logic ill, input logic tmo);
    outs_t e = '0;
    e.st = TRAP; e.illegal_op = ill; e.mem_timeout = tmo;
    return e;
  endfunction

  task automatic compare_next();
    outs_t e, o;
    string t;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = observed();
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", t, o, e);
    end
  endtask

  // Drive this cycle's inputs, check the settled outputs, then advance one edge.
  task automatic step(input string t, input logic rdy, input logic [5:0] opc, input outs_t e);
    mem_ready = rdy;
    opcode    = opc;
    exp_q.push_back(e);
    tag_q.push_back(t);
    #1;
    compare_next();
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset_check(input string t);
    rst_n = 1'b0;
    exp_q.push_back(e_idle());
    tag_q.push_back(t);
    #1;
    compare_next();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_itype(input logic [5:0] opc, input logic [2:0] op, input logic z);
    step("fetch_i", 1'b1, JUNK, e_fetch(1'b1));
    step("decode_i", 1'b1, opc, e_decode());
    step("exec_i", 1'b1, opc, e_exec_i(op, z));
    step("wb_i", 1'b1, JUNK, e_wb_i());
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = '0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(e_idle());
    tag_q.push_back("reset_state");
    compare_next();
    rst_n = 1'b1;

    // R-type, memory always ready
    step("idle_release", 1'b1, 6'b000000, e_idle());
    step("fetch_r", 1'b1, JUNK, e_fetch(1'b1));
    step("decode_r", 1'b1, 6'b000000, e_decode());
    step("exec_r", 1'b1, JUNK, e_exec_r());
    step("wb_r", 1'b1, JUNK, e_wb_r());

    // lw with three wait cycles in MEM_RD
    step("fetch_lw", 1'b1, JUNK, e_fetch(1'b1));
    step("decode_lw", 1'b1, 6'b100011, e_decode());
    step("maddr_lw", 1'b1, 6'b100011, e_maddr());
    for (int i = 0; i < 3; i++) step("mem_rd_wait", 1'b0, JUNK, e_mrd());
    step("mem_rd_done", 1'b1, JUNK, e_mrd());
    step("wb_mem", 1'b1, JUNK, e_wbm());

    // sw, then FETCH must reassert the read request immediately
    step("fetch_sw", 1'b1, JUNK, e_fetch(1'b1));
    step("decode_sw", 1'b1, 6'b101011, e_decode());
    step("maddr_sw", 1'b1, 6'b101011, e_maddr());
    step("mem_wr", 1'b1, JUNK, e_mwr());

    // bne / beq / j
    step("fetch_bne", 1'b1, JUNK, e_fetch(1'b1));
    step("decode_bne", 1'b1, 6'b000101, e_decode());
    step("branch_bne", 1'b1, 6'b000101, e_branch(1'b1));
    step("fetch_beq", 1'b1, JUNK, e_fetch(1'b1));
    step("decode_beq", 1'b1, 6'b000100, e_decode());
    step("branch_beq", 1'b1, 6'b000100, e_branch(1'b0));
    step("fetch_j", 1'b1, JUNK, e_fetch(1'b1));
    step("decode_j", 1'b1, 6'b000010, e_decode());
    step("jump", 1'b1, JUNK, e_jump());

    run_itype(6'b001000, 3'b011, 1'b0);
    run_itype(6'b001100, 3'b100, 1'b1);
    run_itype(6'b001101, 3'b101, 1'b1);
    run_itype(6'b001010, 3'b110, 1'b0);

    // Ready arriving exactly at the timeout limit still completes the fetch
    for (int i = 0; i < 4; i++) step("fetch_wait", 1'b0, JUNK, e_fetch(1'b0));
    step("fetch_ready_at_limit", 1'b1, JUNK, e_fetch(1'b1));
    step("decode_after_limit", 1'b1, 6'b000000, e_decode());
    step("exec_r2", 1'b1, JUNK, e_exec_r());
    step("wb_r2", 1'b1, JUNK, e_wb_r());

    // Illegal opcode traps and stays trapped until reset
    step("fetch_ill", 1'b1, JUNK, e_fetch(1'b1));
    step("decode_ill", 1'b1, 6'b111111, e_decode());
    step("trap_ill_a", 1'b1, 6'b000000, e_trap(1'b1, 1'b0));
    step("trap_ill_b", 1'b1, 6'b100011, e_trap(1'b1, 1'b0));
    async_reset_check("reset_clears_trap");

    // Fetch timeout: four counted waits, trap on the following edge
    step("idle_after_reset", 1'b1, JUNK, e_idle());
    for (int i = 0; i < 5; i++) step("fetch_no_ready", 1'b0, JUNK, e_fetch(1'b0));
    step("trap_tmo_a", 1'b1, JUNK, e_trap(1'b0, 1'b1));
    step("trap_tmo_b", 1'b1, JUNK, e_trap(1'b0, 1'b1));
    async_reset_check("reset_clears_tmo");

    // Reset in the middle of a store drops mem_write without waiting for an edge
    step("idle_sw2", 1'b1, JUNK, e_idle());
    step("fetch_sw2", 1'b1, JUNK, e_fetch(1'b1));
    step("decode_sw2", 1'b1, 6'b101011, e_decode());
    step("maddr_sw2", 1'b1, 6'b101011, e_maddr());
    step("mem_wr_wait", 1'b0, JUNK, e_mwr());
    exp_q.push_back(e_mwr());
    tag_q.push_back("mem_wr_held");
    mem_ready = 1'b0;
    #1;
    compare_next();
    async_reset_check("reset_mid_mem_wr");
    step("idle_final", 1'b1, JUNK, e_idle());
    step("fetch_final", 1'b1, JUNK, e_fetch(1'b1));

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
